// File: rtl/dac_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : dac_spi_rx
// Description : Eight-lane SPI frame receiver for the DAC serial outputs
//               (DAC_SYNC / DAC_SCLK / DAC_DIN). Decodes 24-bit AD5662-style
//               frames (6 don't-care, 2 power-down, 16 data bits, MSB first)
//               into per-lane words held under a valid/ack handshake.
//               Malformed frames raise a one-cycle rx_err pulse, and a word
//               overwritten before it was acknowledged sets a sticky
//               rx_overrun bit.
// Options     : DAC_SPI_RX_SYNC_EN - when defined, adds a 2-flop
//               metastability synchronizer on SYNC/SCLK/DIN ahead of the
//               sampling stage (latency 4 dataclk edges instead of 2).
// Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_rx #(
   parameter int N_LANES    = 8,
   parameter int FRAME_BITS = 24,
   parameter int DATA_BITS  = 16
) (
   input  logic                           dataclk,
   input  logic                           reset_n,
   input  logic [N_LANES-1:0]             DAC_SYNC,
   input  logic [N_LANES-1:0]             DAC_SCLK,
   input  logic [N_LANES-1:0]             DAC_DIN,
   input  logic [N_LANES-1:0]             rx_ack,
   input  logic                           ovr_clr,
   output logic [N_LANES*DATA_BITS-1:0]   rx_data,
   output logic [N_LANES*2-1:0]           rx_pd,
   output logic [N_LANES-1:0]             rx_valid,
   output logic [N_LANES-1:0]             rx_err,
   output logic [N_LANES-1:0]             rx_overrun
);

   // Frame bit count that marks a well-formed frame (5-bit counter domain).
   localparam logic [4:0] c_frame_cnt = 5'(FRAME_BITS);

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Optional synchronizer in front of the sampling stage
   // -------------------------------------------------------------------------
   logic [N_LANES-1:0] w_sync_in;
   logic [N_LANES-1:0] w_sclk_in;
   logic [N_LANES-1:0] w_din_in;

`ifdef DAC_SPI_RX_SYNC_EN
   logic [N_LANES-1:0] r_m1_sync, r_m2_sync;
   logic [N_LANES-1:0] r_m1_sclk, r_m2_sclk;
   logic [N_LANES-1:0] r_m1_din,  r_m2_din;

   // Two-flop synchronizer for lines arriving from pins or another clock domain.
   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         r_m1_sync <= '0;
         r_m2_sync <= '0;
         r_m1_sclk <= '0;
         r_m2_sclk <= '0;
         r_m1_din  <= '0;
         r_m2_din  <= '0;
      end else begin
         r_m1_sync <= DAC_SYNC;
         r_m2_sync <= r_m1_sync;
         r_m1_sclk <= DAC_SCLK;
         r_m2_sclk <= r_m1_sclk;
         r_m1_din  <= DAC_DIN;
         r_m2_din  <= r_m1_din;
      end
   end

   assign w_sync_in = r_m2_sync;
   assign w_sclk_in = r_m2_sclk;
   assign w_din_in  = r_m2_din;
`else
   assign w_sync_in = DAC_SYNC;
   assign w_sclk_in = DAC_SCLK;
   assign w_din_in  = DAC_DIN;
`endif

   // -------------------------------------------------------------------------
   // Sampling (s_*) and one-cycle delayed (p_*) stage for edge detection
   // -------------------------------------------------------------------------
   logic [N_LANES-1:0] r_s_sync, r_p_sync;
   logic [N_LANES-1:0] r_s_sclk, r_p_sclk;
   logic [N_LANES-1:0] r_s_din;

   // SYNC resets low so a lane sees a genuine high level before it arms;
   // this keeps a frame already in progress at reset release from capture.
   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         r_s_sync <= '0;
         r_p_sync <= '0;
         r_s_sclk <= '0;
         r_p_sclk <= '0;
         r_s_din  <= '0;
      end else begin
         r_s_sync <= w_sync_in;
         r_p_sync <= r_s_sync;
         r_s_sclk <= w_sclk_in;
         r_p_sclk <= r_s_sclk;
         r_s_din  <= w_din_in;
      end
   end

   logic [N_LANES-1:0] w_sclk_fall;
   logic [N_LANES-1:0] w_sync_fall;
   logic [N_LANES-1:0] w_sync_rise;

   assign w_sclk_fall = r_p_sclk & ~r_s_sclk;
   assign w_sync_fall = r_p_sync & ~r_s_sync;
   assign w_sync_rise = ~r_p_sync & r_s_sync;

   // -------------------------------------------------------------------------
   // Per-lane frame decoder and output handshake
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
         state_t                r_state;
         logic [4:0]            r_cnt;
         logic [FRAME_BITS-1:0] r_sr;
         logic [DATA_BITS-1:0]  r_data;
         logic [1:0]            r_pd;
         logic                  r_valid;
         logic                  r_err;
         logic                  r_ovr;

         logic w_bit;
         logic w_commit;
         logic w_bad;
         logic w_ack;
         logic w_unused_sr_msbs;

         // A data bit is an SCLK fall seen while the frame strobe is low.
         assign w_bit    = w_sclk_fall[gi] & ~r_s_sync[gi];
         assign w_ack    = rx_ack[gi];
         assign w_commit = (r_state == ST_SHIFT) && w_sync_rise[gi] &&
                           (r_cnt == c_frame_cnt);
         assign w_bad    = w_sync_rise[gi] &&
                           (((r_state == ST_SHIFT) && (r_cnt != c_frame_cnt)) ||
                            (r_state == ST_OVER));

         // The don't-care header bits are shifted through but never reported.
         assign w_unused_sr_msbs = ^r_sr[FRAME_BITS-1:DATA_BITS+2];

         // Frame FSM plus registered word/valid/error/overrun outputs.
         always_ff @(posedge dataclk or negedge reset_n) begin
            if (!reset_n) begin
               r_state <= ST_ARM;
               r_cnt   <= '0;
               r_sr    <= '0;
               r_data  <= '0;
               r_pd    <= '0;
               r_valid <= 1'b0;
               r_err   <= 1'b0;
               r_ovr   <= 1'b0;
            end else begin
               case (r_state)
                  ST_ARM: begin
                     if (r_s_sync[gi]) begin
                        r_state <= ST_IDLE;
                     end
                  end
                  ST_IDLE: begin
                     if (w_sync_fall[gi]) begin
                        r_state <= ST_SHIFT;
                        // An SCLK fall coincident with the SYNC fall is bit 1.
                        if (w_bit) begin
                           r_cnt <= 5'd1;
                           r_sr  <= {{(FRAME_BITS-1){1'b0}}, r_s_din[gi]};
                        end else begin
                           r_cnt <= '0;
                           r_sr  <= '0;
                        end
                     end
                  end
                  ST_SHIFT: begin
                     if (w_sync_rise[gi]) begin
                        r_state <= ST_IDLE;
                     end else if (w_bit) begin
                        if (r_cnt == c_frame_cnt) begin
                           // One fall too many: frame is already malformed.
                           r_state <= ST_OVER;
                        end else begin
                           r_sr  <= {r_sr[FRAME_BITS-2:0], r_s_din[gi]};
                           r_cnt <= r_cnt + 5'd1;
                        end
                     end
                  end
                  ST_OVER: begin
                     if (w_sync_rise[gi]) begin
                        r_state <= ST_IDLE;
                     end
                  end
                  default: begin
                     r_state <= ST_ARM;
                  end
               endcase

               r_err <= w_bad;

               // A commit always wins over an ack: the new word stays valid.
               if (w_commit) begin
                  r_data  <= r_sr[DATA_BITS-1:0];
                  r_pd    <= r_sr[DATA_BITS+1:DATA_BITS];
                  r_valid <= 1'b1;
               end else if (w_ack && r_valid) begin
                  r_valid <= 1'b0;
               end

               // Clearing the sticky overrun takes priority over setting it.
               if (ovr_clr) begin
                  r_ovr <= 1'b0;
               end else if (w_commit && r_valid && !w_ack) begin
                  r_ovr <= 1'b1;
               end
            end
         end

         assign rx_data[gi*DATA_BITS +: DATA_BITS] = r_data;
         assign rx_pd[gi*2 +: 2]                   = r_pd;
         assign rx_valid[gi]                       = r_valid;
         assign rx_err[gi]                         = r_err;
         assign rx_overrun[gi]                     = r_ovr;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_spi_rx
// Description : Directed bench for dac_spi_rx. Frames are driven per lane;
//               well-formed frames push their expected word onto a
//               scoreboard that is popped when the lane raises rx_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_rx;
   localparam int N = 8;

   logic              dataclk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      dac_sync;
   logic [N-1:0]      dac_sclk;
   logic [N-1:0]      dac_din;
   logic [N-1:0]      rx_ack;
   logic              ovr_clr;
   logic [N*16-1:0]   rx_data;
   logic [N*2-1:0]    rx_pd;
   logic [N-1:0]      rx_valid;
   logic [N-1:0]      rx_err;
   logic [N-1:0]      rx_overrun;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          lane;
      logic [15:0] data;
      logic [1:0]  pd;
   } exp_t;
   exp_t sb[$];

   // Bench model of the held output state.
   logic [N-1:0]    m_valid;
   logic [N-1:0]    m_ovr;
   logic [N*16-1:0] m_data;
   logic [N*2-1:0]  m_pd;

   always #5 dataclk = ~dataclk;

   dac_spi_rx #(.N_LANES(N), .FRAME_BITS(24), .DATA_BITS(16)) dut (
      .dataclk    (dataclk),
      .reset_n    (reset_n),
      .DAC_SYNC   (dac_sync),
      .DAC_SCLK   (dac_sclk),
      .DAC_DIN    (dac_din),
      .rx_ack     (rx_ack),
      .ovr_clr    (ovr_clr),
      .rx_data    (rx_data),
      .rx_pd      (rx_pd),
      .rx_valid   (rx_valid),
      .rx_err     (rx_err),
      .rx_overrun (rx_overrun)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_valid"},   rx_valid,   m_valid);
      check({tag, "_data"},    rx_data,    m_data);
      check({tag, "_pd"},      rx_pd,      m_pd);
      check({tag, "_overrun"}, rx_overrun, m_ovr);
   endtask

   // Clock nbits of value out MSB first; SCLK period is 8 dataclk cycles.
   task automatic send_bits(input int lane, input logic [31:0] value, input int nbits);
      for (int b = nbits - 1; b >= 0; b--) begin
         dac_sclk[lane] = 1'b1;
         dac_din[lane]  = value[b];
         repeat (4) @(negedge dataclk);
         dac_sclk[lane] = 1'b0;
         repeat (4) @(negedge dataclk);
      end
   endtask

   task automatic send_frame(input int lane, input logic [31:0] value, input int nbits);
      dac_sync[lane] = 1'b0;
      repeat (2) @(negedge dataclk);
      send_bits(lane, value, nbits);
      if (nbits == 24) begin
         sb.push_back('{lane: lane, data: value[15:0], pd: value[17:16]});
      end
      dac_sync[lane] = 1'b1;
   endtask

   // Called right after SYNC was raised; follows the two-edge commit window.
   task automatic close_frame(input int lane, input bit good, input bit ack_at_commit);
      logic [N-1:0] e_err;
      exp_t         e;
      e_err = '0;
      @(posedge dataclk); #1;
      check("edge1_err", rx_err, '0);
      check("edge1_valid", rx_valid, m_valid);
      if (ack_at_commit) begin
         @(negedge dataclk);
         rx_ack[lane] = 1'b1;
      end
      @(posedge dataclk); #1;
      if (!good) e_err[lane] = 1'b1;
      check("commit_err", rx_err, e_err);
      if (good) begin
         check("commit_valid", rx_valid[lane], 1'b1);
         if (rx_valid[lane]) begin
            if (sb.size() == 0) begin
               check("sb_nonempty", 1'b0, 1'b1);
            end else begin
               e = sb.pop_front();
               check("sb_lane", rx_valid[e.lane], 1'b1);
               check("sb_data", rx_data[e.lane*16 +: 16], e.data);
               check("sb_pd",   rx_pd[e.lane*2 +: 2],     e.pd);
               if (m_valid[e.lane] && !ack_at_commit) m_ovr[e.lane] = 1'b1;
               m_valid[e.lane]         = 1'b1;
               m_data[e.lane*16 +: 16] = e.data;
               m_pd[e.lane*2 +: 2]     = e.pd;
            end
         end
      end
      check_all("commit");
      @(negedge dataclk);
      rx_ack[lane] = 1'b0;
      @(posedge dataclk); #1;
      check("err_one_cycle", rx_err, '0);
   endtask

   task automatic ack_pulse(input int lane);
      @(negedge dataclk);
      rx_ack[lane] = 1'b1;
      @(posedge dataclk); #1;
      m_valid[lane] = 1'b0;
      check("ack_valid", rx_valid, m_valid);
      @(negedge dataclk);
      rx_ack[lane] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n  = 1'b0;
      dac_sync = '1;
      dac_sclk = '0;
      dac_din  = '0;
      rx_ack   = '0;
      ovr_clr  = 1'b0;
      m_valid  = '0;
      m_ovr    = '0;
      m_data   = '0;
      m_pd     = '0;

      // Reset state
      repeat (3) @(negedge dataclk);
      check_all("reset");
      check("reset_err", rx_err, '0);
      reset_n = 1'b1;
      repeat (3) @(negedge dataclk);

      // Lane 0 basic frame, other lanes untouched
      send_frame(0, 32'h008000, 24);
      close_frame(0, 1'b1, 1'b0);
      check("lane0_only_valid", rx_valid, 8'h01);
      ack_pulse(0);

      // Lane 3 with power-down bits, then ack
      send_frame(3, 32'h011234, 24);
      close_frame(3, 1'b1, 1'b0);
      check("lane3_pd", rx_pd[7:6], 2'b01);
      ack_pulse(3);

      // Lane 1 short (20 bits) and long (26 bits) frames
      send_frame(1, 32'h000ABCDE, 20);
      close_frame(1, 1'b0, 1'b0);
      send_frame(1, 32'h03FFFFFF, 26);
      close_frame(1, 1'b0, 1'b0);

      // Lane 2 overrun, then ovr_clr
      send_frame(2, 32'h00AAAA, 24);
      close_frame(2, 1'b1, 1'b0);
      send_frame(2, 32'h005555, 24);
      close_frame(2, 1'b1, 1'b0);
      check("lane2_overrun", rx_overrun[2], 1'b1);
      @(negedge dataclk);
      ovr_clr = 1'b1;
      @(posedge dataclk); #1;
      m_ovr = '0;
      check("ovr_clr", rx_overrun, m_ovr);
      @(negedge dataclk);
      ovr_clr = 1'b0;
      ack_pulse(2);

      // Lane 0 commit coincident with ack
      send_frame(0, 32'h00ABCD, 24);
      close_frame(0, 1'b1, 1'b0);
      send_frame(0, 32'h031357, 24);
      close_frame(0, 1'b1, 1'b1);
      check("collide_no_ovr", rx_overrun[0], 1'b0);
      ack_pulse(0);

      // Leave lane 5 holding a word so reset has something to clear
      send_frame(5, 32'h00C0DE, 24);
      close_frame(5, 1'b1, 1'b0);

      // Reset in the middle of a lane-0 frame, released with SYNC low
      @(negedge dataclk);
      dac_sync[0] = 1'b0;
      repeat (2) @(negedge dataclk);
      send_bits(0, 32'h00F0F0 >> 14, 10);
      reset_n = 1'b0;
      #1;
      m_valid = '0;
      m_ovr   = '0;
      m_data  = '0;
      m_pd    = '0;
      check_all("midreset");
      repeat (2) @(negedge dataclk);
      reset_n = 1'b1;
      send_bits(0, 32'h00F0F0, 14);
      dac_sync[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge dataclk); #1;
         check("post_reset_err", rx_err, '0);
         check("post_reset_valid", rx_valid, '0);
      end
      repeat (2) @(negedge dataclk);

      // Next full frame after reset decodes normally
      send_frame(0, 32'h02BEEF, 24);
      close_frame(0, 1'b1, 1'b0);
      check("after_reset_pd", rx_pd[1:0], 2'b10);

      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
